fb_rect_filler: RTL and testbench

- Avalon-MM slave drawing engine directly upstream of the VGA framebuffer peripheral.
- Software programs a rectangle (x, y, width, height, colour) and writes START.
- The block walks the clipped rectangle in row-major order and emits one framebuffer write per accepted pixel: linear address y*640+x, 8-bit data, with a valid/ready handshake.
- It replaces per-pixel CPU register pokes.

---
 rtl/fb_pkg.sv | 37 +++
 rtl/fb_rect_regs.sv | 110 +++++++++++
 rtl/fb_rect_filler.sv | 173 +++++++++++++++++
 tb/tb_fb_rect_filler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, register map and state type for the rectangle filler
package fb_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    localparam logic [3:0] REG_X_HI   = 4'd0;
    localparam logic [3:0] REG_X_LO   = 4'd1;
    localparam logic [3:0] REG_Y_HI   = 4'd2;
    localparam logic [3:0] REG_Y_LO   = 4'd3;
    localparam logic [3:0] REG_W_HI   = 4'd4;
    localparam logic [3:0] REG_W_LO   = 4'd5;
    localparam logic [3:0] REG_H_HI   = 4'd6;
    localparam logic [3:0] REG_H_LO   = 4'd7;
    localparam logic [3:0] REG_COLOR  = 4'd8;
    localparam logic [3:0] REG_CTRL   = 4'd9;
    localparam logic [3:0] REG_STATUS = 4'd9;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_EMPTY = 2;

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} fill_state_t;

    // Exclusive end coordinate, clipped to the screen edge; 17 bits so base+len cannot wrap.
    function automatic logic [16:0] clip_end(input logic [15:0] base, input logic [15:0] len,
                                             input logic [16:0] limit);
        logic [16:0] sum;
        sum = {1'b0, base} + {1'b0, len};
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/fb_rect_regs.sv
// rtl/fb_rect_regs.sv - Avalon register file, START/ABORT pulses, status flags and read pipeline
module fb_rect_regs
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [3:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    input  logic        busy,
    input  logic        set_done,
    input  logic        set_empty,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [15:0] w,
    output logic [15:0] h,
    output logic [7:0]  color,
    output logic        start,
    output logic        abort,
    output logic        done,
    output logic        empty,
    output logic        irq
);

    logic       wr;
    logic       rd;
    logic       wr_ctrl;
    logic       irq_en;
    logic [7:0] rd_mux;

    assign wr      = chipselect && write;
    assign rd      = chipselect && read;
    assign wr_ctrl = wr && (address == REG_CTRL);

    // START only counts when idle, ABORT only when busy; this resolves a combined write.
    assign start = wr_ctrl && writedata[CTRL_START] && !busy;
    assign abort = wr_ctrl && writedata[CTRL_ABORT] && busy;
    assign irq   = done && irq_en;

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_X_HI:   rd_mux = x[15:8];
            REG_X_LO:   rd_mux = x[7:0];
            REG_Y_HI:   rd_mux = y[15:8];
            REG_Y_LO:   rd_mux = y[7:0];
            REG_W_HI:   rd_mux = w[15:8];
            REG_W_LO:   rd_mux = w[7:0];
            REG_H_HI:   rd_mux = h[15:8];
            REG_H_LO:   rd_mux = h[7:0];
            REG_COLOR:  rd_mux = color;
            REG_STATUS: rd_mux = {5'b0, empty, done, busy};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            w        <= '0;
            h        <= '0;
            color    <= '0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
            empty    <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr && !busy) begin
                case (address)
                    REG_X_HI:  x[15:8] <= writedata;
                    REG_X_LO:  x[7:0]  <= writedata;
                    REG_Y_HI:  y[15:8] <= writedata;
                    REG_Y_LO:  y[7:0]  <= writedata;
                    REG_W_HI:  w[15:8] <= writedata;
                    REG_W_LO:  w[7:0]  <= writedata;
                    REG_H_HI:  h[15:8] <= writedata;
                    REG_H_LO:  h[7:0]  <= writedata;
                    REG_COLOR: color   <= writedata;
                    default:   ;
                endcase
            end
            if (wr_ctrl) begin
                irq_en <= writedata[CTRL_IRQ_EN];
            end

            // A completion event beats a simultaneous STATUS read so it is never lost.
            if (start) begin
                done  <= 1'b0;
                empty <= 1'b0;
            end else if (set_done) begin
                done <= 1'b1;
                if (set_empty) begin
                    empty <= 1'b1;
                end
            end else if (rd && (address == REG_STATUS)) begin
                done  <= 1'b0;
                empty <= 1'b0;
            end

            if (rd) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: rtl/fb_rect_filler.sv
// rtl/fb_rect_filler.sv - rectangle fill engine: clip, walk row-major, emit framebuffer writes
module fb_rect_filler #(
    parameter int H_RES  = fb_pkg::H_RES,
    parameter int V_RES  = fb_pkg::V_RES,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [3:0]        address,
    input  logic [7:0]        writedata,
    output logic [7:0]        readdata,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_address,
    output logic [DATA_W-1:0] fb_data,
    output logic              irq
);
    import fb_pkg::*;

    fill_state_t state;
    fill_state_t state_n;

    logic              start;
    logic              abort;
    logic              busy;
    logic              set_done;
    logic              set_empty;
    logic              done;
    logic              empty;
    logic [15:0]       reg_x;
    logic [15:0]       reg_y;
    logic [15:0]       reg_w;
    logic [15:0]       reg_h;
    logic [7:0]        reg_color;

    logic [15:0]       s_x;
    logic [15:0]       s_y;
    logic [15:0]       s_w;
    logic [15:0]       s_h;
    logic [7:0]        s_color;
    logic [16:0]       x_end;
    logic [16:0]       y_end;
    logic [15:0]       cx;
    logic [15:0]       cy;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_base_init;
    logic              rect_empty;
    logic              col_last;
    logic              row_last;
    logic              handshake;

    fb_rect_regs u_regs (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .busy       (busy),
        .set_done   (set_done),
        .set_empty  (set_empty),
        .x          (reg_x),
        .y          (reg_y),
        .w          (reg_w),
        .h          (reg_h),
        .color      (reg_color),
        .start      (start),
        .abort      (abort),
        .done       (done),
        .empty      (empty),
        .irq        (irq)
    );

    assign busy       = (state != IDLE);
    assign rect_empty = (s_w == '0) || (s_h == '0) ||
                        (s_x >= 16'(H_RES)) || (s_y >= 16'(V_RES));
    // 640 = 512 + 128: two shifts and an add instead of a multiplier.
    assign row_base_init = (H_RES == 640) ?
                           ((ADDR_W'(s_y) << 9) + (ADDR_W'(s_y) << 7)) :
                           (ADDR_W'(s_y) * ADDR_W'(H_RES));
    assign col_last   = (({1'b0, cx} + 17'd1) >= x_end);
    assign row_last   = (({1'b0, cy} + 17'd1) == y_end);
    assign handshake  = (state == RUN) && fb_ready;

    assign fb_we      = (state == RUN);
    assign fb_address = fb_we ? (row_base + ADDR_W'(cx)) : '0;
    assign fb_data    = fb_we ? DATA_W'(s_color) : '0;

    always_comb begin
        state_n   = state;
        set_done  = 1'b0;
        set_empty = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (abort) begin
                    state_n  = IDLE;
                    set_done = 1'b1;
                end else if (rect_empty) begin
                    state_n   = IDLE;
                    set_done  = 1'b1;
                    set_empty = 1'b1;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n  = IDLE;
                    set_done = 1'b1;
                end else if (fb_ready && col_last && row_last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                set_done = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            s_x      <= '0;
            s_y      <= '0;
            s_w      <= '0;
            s_h      <= '0;
            s_color  <= '0;
            x_end    <= '0;
            y_end    <= '0;
            cx       <= '0;
            cy       <= '0;
            row_base <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                s_x     <= reg_x;
                s_y     <= reg_y;
                s_w     <= reg_w;
                s_h     <= reg_h;
                s_color <= reg_color;
            end
            if (state == SETUP) begin
                x_end    <= clip_end(s_x, s_w, 17'(H_RES));
                y_end    <= clip_end(s_y, s_h, 17'(V_RES));
                cx       <= s_x;
                cy       <= s_y;
                row_base <= row_base_init;
            end else if (handshake) begin
                if (!col_last) begin
                    cx <= cx + 16'd1;
                end else begin
                    cx       <= s_x;
                    cy       <= cy + 16'd1;
                    row_base <= row_base + ADDR_W'(H_RES);
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_rect_filler.sv
// tb/tb_fb_rect_filler.sv - directed bench for the rectangle filler
module tb_fb_rect_filler;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [3:0]  address = '0;
    logic [7:0]  writedata = '0;
    logic [7:0]  readdata;
    logic        fb_we;
    logic        fb_ready = 1'b1;
    logic [18:0] fb_address;
    logic [7:0]  fb_data;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    int ready_mode = 0;

    int          hs_count = 0;
    int          we_cycles = 0;
    int          stall_cycles = 0;
    int          stall_bad = 0;
    logic        prev_stall = 1'b0;
    logic [18:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    logic [18:0] got_addr[$];
    logic [7:0]  got_data[$];
    int          exp_addr[$];

    fb_rect_filler dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .fb_address (fb_address),
        .fb_data    (fb_data),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin : ready_drv
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                fb_ready = ((ph % 3) == 0);
                ph++;
            end else begin
                fb_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (prev_stall && (!fb_we || fb_address != prev_addr || fb_data != prev_data))
            stall_bad <= stall_bad + 1;
        prev_stall <= fb_we && !fb_ready;
        prev_addr  <= fb_address;
        prev_data  <= fb_data;
        if (fb_we) we_cycles <= we_cycles + 1;
        if (fb_we && !fb_ready) stall_cycles <= stall_cycles + 1;
        if (fb_we && fb_ready) begin
            hs_count <= hs_count + 1;
            got_addr.push_back(fb_address);
            got_data.push_back(fb_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        step(1);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        step(1);
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
    endtask

    task automatic check_read(input string tag, input logic [3:0] a, input int exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, int'(d), exp);
    endtask

    task automatic program_rect(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w,
                                input logic [15:0] h, input logic [7:0] c);
        bus_write(REG_X_HI, x[15:8]);
        bus_write(REG_X_LO, x[7:0]);
        bus_write(REG_Y_HI, y[15:8]);
        bus_write(REG_Y_LO, y[7:0]);
        bus_write(REG_W_HI, w[15:8]);
        bus_write(REG_W_LO, w[7:0]);
        bus_write(REG_H_HI, h[15:8]);
        bus_write(REG_H_LO, h[7:0]);
        bus_write(REG_COLOR, c);
    endtask

    task automatic check_pixels(input string tag, input int base, input int color);
        check({tag, "_count"}, hs_count - base, exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (base + i < got_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), int'(got_addr[base + i]), exp_addr[i]);
                check($sformatf("%s_data%0d", tag, i), int'(got_data[base + i]), color);
            end
        end
    endtask

    initial begin
        int base;
        int wb;
        int sb;
        int sc;
        int guard;
        logic [7:0] d;

        step(3);
        reset = 1'b0;
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_fb_address", int'(fb_address), 0);
        check("rst_fb_data", int'(fb_data), 0);
        check("rst_readdata", int'(readdata), 0);
        check("rst_irq", int'(irq), 0);
        check_read("rst_status", REG_STATUS, 'h00);

        // Basic 3x2 fill, latency and throughput
        program_rect(16'd10, 16'd20, 16'd3, 16'd2, 8'hAA);
        base = hs_count;
        wb   = we_cycles;
        bus_write(REG_CTRL, 8'h01);
        check("lat_setup_we", int'(fb_we), 0);
        step(1);
        check("lat_first_we", int'(fb_we), 1);
        step(12);
        exp_addr = '{12810, 12811, 12812, 13450, 13451, 13452};
        check_pixels("basic", base, 'hAA);
        check("basic_we_cycles", we_cycles - wb, 6);
        check_read("basic_status", REG_STATUS, 'h02);
        check("basic_irq_off", int'(irq), 0);
        check_read("basic_status_clr", REG_STATUS, 'h00);

        // Same rectangle with back-pressure
        ready_mode = 1;
        base = hs_count;
        sb   = stall_bad;
        sc   = stall_cycles;
        bus_write(REG_CTRL, 8'h01);
        step(45);
        ready_mode = 0;
        step(1);
        check_pixels("stall", base, 'hAA);
        check("stall_stable", stall_bad - sb, 0);
        check("stall_seen", int'(stall_cycles - sc > 0), 1);
        check_read("stall_status", REG_STATUS, 'h02);

        // Clipping at the bottom-right corner
        program_rect(16'd638, 16'd478, 16'd5, 16'd5, 8'h3C);
        base = hs_count;
        bus_write(REG_CTRL, 8'h01);
        step(12);
        exp_addr = '{306558, 306559, 307198, 307199};
        check_pixels("clip", base, 'h3C);
        check_read("clip_status", REG_STATUS, 'h02);

        // Empty rectangles
        program_rect(16'd10, 16'd20, 16'd0, 16'd2, 8'h11);
        wb = we_cycles;
        bus_write(REG_CTRL, 8'h01);
        step(5);
        check("w0_no_we", we_cycles - wb, 0);
        check_read("w0_status", REG_STATUS, 'h06);
        check_read("w0_status_clr", REG_STATUS, 'h00);
        program_rect(16'd640, 16'd20, 16'd3, 16'd2, 8'h11);
        wb = we_cycles;
        bus_write(REG_CTRL, 8'h01);
        step(5);
        check("x640_no_we", we_cycles - wb, 0);
        check_read("x640_status", REG_STATUS, 'h06);
        program_rect(16'd0, 16'd480, 16'd3, 16'd2, 8'h11);
        wb = we_cycles;
        bus_write(REG_CTRL, 8'h01);
        step(5);
        check("y480_no_we", we_cycles - wb, 0);
        check_read("y480_status", REG_STATUS, 'h06);

        // 100x100 fill aborted after 37 handshakes
        program_rect(16'd0, 16'd0, 16'd100, 16'd100, 8'h33);
        base = hs_count;
        bus_write(REG_CTRL, 8'h01);
        bus_write(REG_COLOR, 8'h55);
        bus_read(REG_COLOR, d);
        check("busy_color_kept", int'(d), 'h33);
        check_read("busy_status", REG_STATUS, 'h01);
        guard = 0;
        while ((hs_count - base < 37) && (guard < 300)) begin
            step(1);
            guard++;
        end
        check("abort_reach37", hs_count - base, 37);
        bus_write(REG_CTRL, 8'h02);
        check("abort_we_low", int'(fb_we), 0);
        step(4);
        check("abort_total", hs_count - base, 38);
        if (base + 37 < got_addr.size()) begin
            check("abort_last_addr", int'(got_addr[base + 37]), 37);
            check("abort_last_data", int'(got_data[base + 37]), 'h33);
        end
        check_read("abort_status", REG_STATUS, 'h02);

        // Reset in the middle of a fill
        program_rect(16'd0, 16'd0, 16'd100, 16'd100, 8'h44);
        bus_write(REG_CTRL, 8'h01);
        step(10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        wb = we_cycles;
        check("mid_rst_we", int'(fb_we), 0);
        check("mid_rst_readdata", int'(readdata), 0);
        step(5);
        check("mid_rst_no_we", we_cycles - wb, 0);
        check_read("mid_rst_x_lo", REG_X_LO, 0);
        check_read("mid_rst_w_lo", REG_W_LO, 0);
        check_read("mid_rst_color", REG_COLOR, 0);
        check_read("mid_rst_status", REG_STATUS, 0);

        // Single pixel with interrupt enabled
        bus_write(REG_W_LO, 8'd1);
        bus_write(REG_H_LO, 8'd1);
        bus_write(REG_COLOR, 8'h5A);
        base = hs_count;
        bus_write(REG_CTRL, 8'h05);
        step(6);
        exp_addr = '{0};
        check_pixels("single", base, 'h5A);
        check("irq_high", int'(irq), 1);
        check_read("single_status", REG_STATUS, 'h02);
        check("irq_cleared", int'(irq), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
